divider: RTL and testbench

- Iterative radix-2 restoring integer divider; the inverse partner of the team's iterative shift-add multiplier in the lab ALU datapath.
- Takes a dividend and divisor on a begin/end handshake and produces quotient and remainder after a fixed iteration count.
- Supports signed mode (magnitude arithmetic with sign fix-up) and unsigned mode.
- Sits beside the multiplier and is driven by the same control unit.

---
 rtl/divider_if.sv | 47 ++++
 rtl/divider.sv | 170 +++++++++++++++++
 tb/tb_divider.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// rtl/divider_if.sv - request/result bundle between the ALU control unit and the divider
//
// Purpose: groups the divider handshake, operands and results so the control
// unit (master) and the divider (slave) share one connection.
// Signals:
//   div_begin    master->slave  request, held high for the whole operation
//   div_signed   master->slave  1 = two's-complement operands
//   div_op1      master->slave  dividend
//   div_op2      master->slave  divisor
//   quotient     slave->master  sign-corrected quotient, valid with div_end
//   remainder    slave->master  sign-corrected remainder, valid with div_end
//   div_end      slave->master  result valid / done
//   div_by_zero  slave->master  divisor was zero, valid with div_end
interface divider_if #(
  parameter int WIDTH = 32
);
  logic             div_begin;
  logic             div_signed;
  logic [WIDTH-1:0] div_op1;
  logic [WIDTH-1:0] div_op2;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_end;
  logic             div_by_zero;

  modport master (
    output div_begin,
    output div_signed,
    output div_op1,
    output div_op2,
    input  quotient,
    input  remainder,
    input  div_end,
    input  div_by_zero
  );

  modport slave (
    input  div_begin,
    input  div_signed,
    input  div_op1,
    input  div_op2,
    output quotient,
    output remainder,
    output div_end,
    output div_by_zero
  );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring divider, signed and unsigned
//
// Purpose: divides div_op1 by div_op2 one quotient bit per clock (WIDTH
// iterations), operating on magnitudes and fixing up signs at the end.
// Ports:
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   dif     divider_if.slave: div_begin/div_signed/div_op1/div_op2 in,
//           quotient/remainder/div_end/div_by_zero out
module divider #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     resetn,
  divider_if.slave dif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_end_q, div_end_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_mag, op2_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    // Negating the most negative value wraps back to 2^(WIDTH-1), which is
    // exactly its magnitude when read as unsigned.
    op1_neg = dif.div_signed & dif.div_op1[WIDTH-1];
    op2_neg = dif.div_signed & dif.div_op2[WIDTH-1];
    op1_mag = op1_neg ? -dif.div_op1 : dif.div_op1;
    op2_mag = op2_neg ? -dif.div_op2 : dif.div_op2;

    // One restoring step on a WIDTH+1 bit path: a borrow out of the top bit
    // means the trial value is smaller than the divisor.
    trial    = {prem_q, dvd_q[WIDTH-1]};
    diff     = trial - {1'b0, dvs_q};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next   = {qacc_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    prem_d        = prem_q;
    qacc_d        = qacc_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_end_d     = div_end_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (dif.div_begin) begin
          q_neg_d = op1_neg ^ op2_neg;
          r_neg_d = op1_neg;
          dvd_d   = op1_mag;
          dvs_d   = op2_mag;
          prem_d  = '0;
          qacc_d  = '0;
          count_d = '0;
          if (dif.div_op2 == '0) begin
            // Zero divisor short-circuits: the raw dividend is returned as
            // the remainder, not its magnitude.
            quotient_d    = '1;
            remainder_d   = dif.div_op1;
            div_by_zero_d = 1'b1;
            div_end_d     = 1'b1;
            state_d       = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!dif.div_begin) begin
          state_d = IDLE;
        end else begin
          dvd_d   = dvd_q << 1;
          prem_d  = rem_next;
          qacc_d  = q_next;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            quotient_d  = q_neg_q ? -q_next : q_next;
            remainder_d = r_neg_q ? -rem_next : rem_next;
            div_end_d   = 1'b1;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        // Holding div_begin high keeps the result; it must fall before the
        // next request can be accepted.
        if (!dif.div_begin) begin
          div_end_d     = 1'b0;
          div_by_zero_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      count_q       <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      prem_q        <= '0;
      qacc_q        <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_end_q     <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      prem_q        <= prem_d;
      qacc_q        <= qacc_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_end_q     <= div_end_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign dif.quotient    = quotient_q;
  assign dif.remainder   = remainder_q;
  assign dif.div_end     = div_end_q;
  assign dif.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for the divider
module tb_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  divider_if #(.WIDTH(W)) dif();

  divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .dif    (dif)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_end = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising div_end consumes one expected result.
  always @(negedge clk) begin
    if (dif.div_end && !prev_end) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_end: got q=%h r=%h expected no result", dif.quotient, dif.remainder);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 64'(dif.quotient), 64'(mon_e.q));
        check("remainder", 64'(dif.remainder), 64'(mon_e.r));
        check("div_by_zero", 64'(dif.div_by_zero), 64'(mon_e.dbz));
        check("latency", 64'(cyc - accept_cyc + 1), 64'(mon_e.lat));
      end
    end
    prev_end = dif.div_end;
  end

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    exp_t e;
    int   k;
    logic hold_ok;
    @(negedge clk);
    dif.div_signed = sgn;
    dif.div_op1    = a;
    dif.div_op2    = b;
    dif.div_begin  = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.lat = edbz ? 1 : W + 1;
    sb.push_back(e);
    accept_cyc = cyc + 1;
    @(negedge clk);
    // Operands are only sampled at accept; disturb them afterwards.
    dif.div_op1    = $urandom;
    dif.div_op2    = $urandom;
    dif.div_signed = ~sgn;
    k = 0;
    while (!dif.div_end && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!dif.div_end) check("end_timeout", 64'(dif.div_end), 64'd1);
    hold_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!(dif.div_end === 1'b1 && dif.quotient === eq && dif.remainder === er &&
            dif.div_by_zero === edbz)) hold_ok = 1'b0;
    end
    check("hold_while_begin", 64'(hold_ok), 64'd1);
    dif.div_begin = 1'b0;
    @(negedge clk);
    check("end_drop", 64'({dif.div_end, dif.div_by_zero}), 64'd0);
    check("result_keep", 64'(dif.quotient), 64'(eq));
  endtask

  initial begin
    logic end_seen;
    dif.div_begin  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_op1    = '0;
    dif.div_op2    = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_q", 64'(dif.quotient), 64'd0);
    check("reset_r", 64'(dif.remainder), 64'd0);
    check("reset_flags", 64'({dif.div_end, dif.div_by_zero}), 64'd0);
    resetn = 1'b1;

    run_op(1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0);
    run_op(1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    run_op(1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0);
    run_op(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0);
    run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
    run_op(1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
    run_op(1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1'b1);
    run_op(1'b0, 32'd9,          32'd3,        32'd3,        32'd0,        1'b0);
    run_op(1'b1, 32'd0,          32'd5,        32'd0,        32'd0,        1'b0);
    run_op(1'b1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
    run_op(1'b0, 32'd7,          32'd100,      32'd0,        32'd7,        1'b0);
    run_op(1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0);

    // Asynchronous reset in the middle of CALC cycle 10.
    @(negedge clk);
    dif.div_signed = 1'b0;
    dif.div_op1    = 32'd100;
    dif.div_op2    = 32'd7;
    dif.div_begin  = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_abort_q", 64'(dif.quotient), 64'd0);
    check("rst_abort_r", 64'(dif.remainder), 64'd0);
    check("rst_abort_flags", 64'({dif.div_end, dif.div_by_zero}), 64'd0);
    dif.div_begin = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    run_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    // div_begin dropped at CALC cycle 20.
    @(negedge clk);
    dif.div_signed = 1'b0;
    dif.div_op1    = 32'd12345;
    dif.div_op2    = 32'd7;
    dif.div_begin  = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    dif.div_begin = 1'b0;
    end_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.div_end !== 1'b0) end_seen = 1'b1;
    end
    check("abort_no_end", 64'(end_seen), 64'd0);
    check("abort_keep_q", 64'(dif.quotient), 64'd100);
    check("abort_keep_r", 64'(dif.remainder), 64'd0);

    run_op(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end
endmodule
